debugger_uart_rx: RTL and testbench

UART receive front end of the debugger. It synchronises the asynchronous `rx` pin and recovers 8N1 frames (one or more stop bits) using mid-bit sampling. Each received byte is presented to the debugger command decoder through a one-entry valid/ready holding register. The block reports framing and overrun errors as single-cycle pulses.

---
 rtl/debugger_pkg.sv | 14 +
 rtl/debugger_sync2.sv | 22 ++
 rtl/debugger_uart_rx.sv | 118 +++++++++++
 tb/tb_debugger_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/debugger_pkg.sv
// Shared debugger UART definitions: receiver state encoding, frame width and
// the default bit period used by both RX and TX sides.
package debugger_pkg;
    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 289;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;
endpackage

// File: rtl/debugger_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so idle-high and idle-low lines both power up quiet.
module debugger_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_Rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/debugger_uart_rx.sv
// Debugger UART receiver: 8N1 mid-bit sampling into a one-entry valid/ready
// holding register, with single-cycle framing and overrun error pulses.
module debugger_uart_rx
    import debugger_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      n_Rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      framing_err,
    output logic                      overrun_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    // Counter expires one cycle after reaching zero, so loads are one short of
    // the wanted interval; this keeps samples exactly CLKS_PER_BIT apart.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    logic                      rx_s;
    logic                      rx_s_p1;
    logic                      fall;
    logic                      tick;
    rx_state_t                 state;
    logic [CNT_W-1:0]          baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;

    debugger_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .n_Rst (n_Rst),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall = rx_s_p1 & ~rx_s;
    assign tick = (baud_cnt == '0);

    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            rx_s_p1     <= 1'b1;
        end else begin
            rx_s_p1     <= rx_s;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (!tick)
                baud_cnt <= baud_cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_cnt <= HALF_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            baud_cnt <= BIT_LOAD;
                            bit_idx  <= '0;
                            state    <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= BIT_LOAD;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            // A same-cycle handshake frees the slot for the new byte.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BRK_WAIT;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath shift register needs no reset: it is fully refilled every frame.
    always_ff @(posedge clk) begin
        if (state == DATA && tick)
            shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
    end
endmodule

// File: tb/tb_debugger_uart_rx.sv
// Directed bench for debugger_uart_rx: table of clean frames plus hand-written
// sequences for hold, overrun, framing, glitch and mid-frame reset.
module tb_debugger_uart_rx;
    localparam int CPB = 289;

    logic       clk;
    logic       n_Rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    int         vcycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    int         rst_bad = 0;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        int         nstop;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    debugger_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_Rst       (n_Rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) vcycles++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (framing_err) fe_cnt++;
        if (overrun_err) ov_cnt++;
        if (framing_err && overrun_err) both_cnt++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (!n_Rst && (rx_valid || framing_err || overrun_err || rx_data != 8'h00))
            rst_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        fe_cnt   = 0;
        ov_cnt   = 0;
        vcycles  = 0;
        both_cnt = 0;
        rise_cyc = -1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int nstop, input logic stop_v);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_v);
        for (int i = 1; i < nstop; i++) drive_bit(1'b1);
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] first_got();
        return (got_q.size() > 0) ? {24'h0, got_q[0]} : 32'hDEAD_BEEF;
    endfunction

    initial begin
        vecs[0] = '{data: 8'h03, nstop: 1, exp_data: 8'h03};
        vecs[1] = '{data: 8'hDE, nstop: 1, exp_data: 8'hDE};
        vecs[2] = '{data: 8'hAD, nstop: 1, exp_data: 8'hAD};
        vecs[3] = '{data: 8'h00, nstop: 2, exp_data: 8'h00};
        vecs[4] = '{data: 8'hFF, nstop: 2, exp_data: 8'hFF};

        // Reset with rx toggling
        n_Rst    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 rx = ~rx;
        end
        check("reset_outputs_quiet", rst_bad, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 8'h00);
        rx = 1'b1;
        @(posedge clk);
        #1 n_Rst = 1'b1;
        clear_mon();
        idle_cycles(20 * CPB);
        check("post_reset_no_valid", vcycles, 0);
        check("post_reset_no_err", fe_cnt + ov_cnt, 0);

        // Single byte held until accepted
        clear_mon();
        send_byte(8'h85, 2, 1'b1);
        check("single_latency_ok", ((rise_cyc - fall_cyc) >= 2747 && (rise_cyc - fall_cyc) <= 2749), 1);
        check("single_valid", rx_valid, 1);
        check("single_data", rx_data, 8'h85);
        idle_cycles(100);
        check("single_held_valid", rx_valid, 1);
        check("single_held_data", rx_data, 8'h85);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        check("single_drop_after_hs", rx_valid, 0);
        check("single_hs_data", first_got(), 8'h85);

        // Table of clean frames, consumer always ready; first three back-to-back
        rx_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            send_byte(vecs[v].data, vecs[v].nstop, 1'b1);
            check($sformatf("vec%0d_count", v), got_q.size(), 1);
            check($sformatf("vec%0d_data", v), first_got(), {24'h0, vecs[v].exp_data});
            check($sformatf("vec%0d_pulse_width", v), vcycles, 1);
            check($sformatf("vec%0d_no_err", v), fe_cnt + ov_cnt, 0);
        end

        // Overrun: second byte lost, first retained
        rx_ready = 1'b0;
        idle_cycles(CPB);
        clear_mon();
        send_byte(8'h11, 2, 1'b1);
        send_byte(8'h22, 2, 1'b1);
        check("overrun_pulses", ov_cnt, 1);
        check("overrun_keeps_data", rx_data, 8'h11);
        check("overrun_valid", rx_valid, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        check("overrun_drop_after_hs", rx_valid, 0);
        check("overrun_hs_data", first_got(), 8'h11);
        check("overrun_no_fe", fe_cnt, 0);

        // Framing error then recovery
        rx_ready = 1'b1;
        clear_mon();
        send_byte(8'h55, 1, 1'b0);
        idle_cycles(2 * CPB);
        check("framing_pulses", fe_cnt, 1);
        check("framing_no_valid", vcycles, 0);
        send_byte(8'hAA, 2, 1'b1);
        check("after_framing_data", first_got(), 8'hAA);
        check("after_framing_count", got_q.size(), 1);
        check("no_simultaneous_errs", both_cnt, 0);

        // Short low glitch
        clear_mon();
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        idle_cycles(3 * CPB);
        check("glitch_no_valid", vcycles, 0);
        check("glitch_no_err", fe_cnt + ov_cnt, 0);

        // Reset during data bit 4 of 8'hF0 while a byte is held
        rx_ready = 1'b0;
        send_byte(8'h7E, 2, 1'b1);
        check("pre_reset_held", rx_data, 8'h7E);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        #1 n_Rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_valid", rx_valid, 0);
        check("midreset_data", rx_data, 8'h00);
        @(posedge clk);
        #1 n_Rst = 1'b1;
        idle_cycles(5 * CPB);
        check("post_midreset_quiet", rx_valid, 0);
        rx_ready = 1'b1;
        clear_mon();
        send_byte(8'h3C, 2, 1'b1);
        check("post_midreset_data", first_got(), 8'h3C);
        check("post_midreset_no_err", fe_cnt + ov_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
